// File: rtl/dpm_pkg.sv
// Shared constants and helpers for the sample packing datapath.
package dpm_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH       = 8;
    localparam int unsigned DEFAULT_SAMPLES_PER_WORD = 4;
    localparam int unsigned DROP_COUNT_WIDTH         = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = int'(i) + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO succeeds only
// when a read happens on the same edge.
module sync_word_fifo
    import dpm_pkg::*;
#(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // The extra pointer bit distinguishes full (wrap bits differ) from empty.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_rd = i_rd_en && !o_empty;
    assign do_wr = i_wr_en && (!o_full || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sample_word_packer.sv
// Packs a stream of unsigned samples into wide words and queues them for a
// valid/ready consumer, flagging and counting words lost to a full queue.
module sample_word_packer
    import dpm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int unsigned SAMPLES_PER_WORD = DEFAULT_SAMPLES_PER_WORD,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_valid,
    input  logic [DATA_WIDTH-1:0]                  i_data,
    input  logic                                   i_flush,
    input  logic                                   i_clear_overflow,
    output logic [DATA_WIDTH*SAMPLES_PER_WORD-1:0] o_data,
    output logic [SAMPLES_PER_WORD-1:0]            o_keep,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic                                   o_overflow,
    output logic [DROP_COUNT_WIDTH-1:0]            o_drop_count
);

    localparam int unsigned LW = clog2(SAMPLES_PER_WORD);
    localparam int unsigned WW = DATA_WIDTH * SAMPLES_PER_WORD;
    localparam int unsigned FW = WW + SAMPLES_PER_WORD;
    localparam logic [LW-1:0] LAST_LANE = LW'(SAMPLES_PER_WORD - 1);

    logic [LW-1:0]               lane_q, lane_d;
    logic [WW-1:0]               asm_q, asm_d;
    logic [WW-1:0]               packed_word;
    logic [LW:0]                 filled;
    logic [SAMPLES_PER_WORD-1:0] keep;
    logic                        close_word;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        drop;
    logic [FW-1:0]               head;
    logic                        overflow_q, overflow_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    // Unfilled lanes of the assembly register are always zero, so a flushed
    // partial word needs no extra masking.
    always_comb begin
        packed_word = asm_q;
        if (i_valid) packed_word[lane_q*DATA_WIDTH +: DATA_WIDTH] = i_data;
        filled     = {1'b0, lane_q} + {{LW{1'b0}}, i_valid};
        close_word = (i_valid && (lane_q == LAST_LANE)) || (i_flush && (filled != '0));
        for (int k = 0; k < int'(SAMPLES_PER_WORD); k++) begin
            keep[k] = ((LW+1)'(k) < filled);
        end
        lane_d = lane_q;
        asm_d  = asm_q;
        if (close_word) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (i_valid) begin
            lane_d = lane_q + LW'(1);
            asm_d  = packed_word;
        end
    end

    assign pop  = !fifo_empty && i_ready;
    assign drop = close_word && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (i_clear_overflow)    drop_cnt_d = DROP_COUNT_WIDTH'(1);
            else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_COUNT_WIDTH'(1);
        end else if (i_clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lane_q     <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (close_word),
        .i_wr_data ({keep, packed_word}),
        .o_full    (fifo_full),
        .i_rd_en   (pop),
        .o_rd_data (head),
        .o_empty   (fifo_empty)
    );

    // Present zeros while empty so stale storage never shows on the outputs.
    assign o_valid      = !fifo_empty;
    assign o_data       = fifo_empty ? '0 : head[WW-1:0];
    assign o_keep       = fifo_empty ? '0 : head[FW-1:WW];
    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sample_word_packer.sv
// Self-checking bench for sample_word_packer: directed scenarios plus a random
// run against a queue-based reference model.
module tb_sample_word_packer;

    localparam int DW    = 8;
    localparam int SPW   = 4;
    localparam int DEPTH = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_flush = 1'b0;
    logic          i_clear_overflow = 1'b0;
    logic          i_ready = 1'b0;
    logic [31:0]   o_data;
    logic [3:0]    o_keep;
    logic          o_valid;
    logic          o_overflow;
    logic [15:0]   o_drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending samples, queued words, drop state.
    logic [7:0]  m_pend[$];
    logic [31:0] m_wdata[$];
    logic [3:0]  m_wkeep[$];
    int          m_drops = 0;
    bit          m_ovf = 0;

    always #5 i_clk = ~i_clk;

    sample_word_packer #(
        .DATA_WIDTH       (DW),
        .SAMPLES_PER_WORD (SPW),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_valid          (i_valid),
        .i_data           (i_data),
        .i_flush          (i_flush),
        .i_clear_overflow (i_clear_overflow),
        .o_data           (o_data),
        .o_keep           (o_keep),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_overflow       (o_overflow),
        .o_drop_count     (o_drop_count)
    );

    task automatic model_step(input bit v, input logic [7:0] d, input bit f, input bit c,
                              input bit r);
        bit          pop;
        bit          close;
        bit          drop;
        logic [31:0] w;
        logic [3:0]  k;
        pop   = (m_wdata.size() > 0) && r;
        close = 0;
        if (v) begin
            m_pend.push_back(d);
            if (m_pend.size() == SPW) close = 1;
        end
        if (f && m_pend.size() > 0) close = 1;
        w = '0;
        k = '0;
        if (close) begin
            for (int i = 0; i < m_pend.size(); i++) begin
                w[i*8 +: 8] = m_pend[i];
                k[i] = 1'b1;
            end
            m_pend.delete();
        end
        drop = close && (m_wdata.size() == DEPTH) && !pop;
        if (pop) begin
            void'(m_wdata.pop_front());
            void'(m_wkeep.pop_front());
        end
        if (close && !drop) begin
            m_wdata.push_back(w);
            m_wkeep.push_back(k);
        end
        if (drop) begin
            m_ovf = 1;
            if (c) m_drops = 1;
            else if (m_drops < 65535) m_drops++;
        end else if (c) begin
            m_ovf   = 0;
            m_drops = 0;
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit c,
                         input bit r);
        i_valid          = v;
        i_data           = d;
        i_flush          = f;
        i_clear_overflow = c;
        i_ready          = r;
        model_step(v, d, f, c, r);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_valid = 0; i_flush = 0; i_clear_overflow = 0; i_ready = 0; i_data = '0;
        m_pend.delete();
        m_wdata.delete();
        m_wkeep.delete();
        m_drops = 0;
        m_ovf   = 0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    function automatic logic [31:0] seq_word(input int base);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(base + j);
        return w;
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({o_valid, o_data, o_keep, o_overflow, o_drop_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%h k=%h ovf=%0b cnt=%0d, want all zero",
                     o_valid, o_data, o_keep, o_overflow, o_drop_count);
        end
    endtask

    task automatic test_full_word();
        do_reset();
        drive(1, 8'h10, 0, 0, 1);
        drive(1, 8'h11, 0, 0, 1);
        drive(1, 8'h12, 0, 0, 1);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word_early_valid: got %0b want 0", o_valid);
        end
        drive(1, 8'h13, 0, 0, 1);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h13121110 || o_keep !== 4'hF) begin
            n_fail++;
            $display("FAIL full_word: got v=%0b d=%h k=%h want v=1 d=13121110 k=f",
                     o_valid, o_data, o_keep);
        end
        drive(0, 8'h00, 0, 0, 1);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word_pop: got v=%0b want 0", o_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 8'hAA, 0, 0, 0);
        drive(1, 8'hBB, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h0000BBAA || o_keep !== 4'h3) begin
            n_fail++;
            $display("FAIL flush_partial: got v=%0b d=%h k=%h want v=1 d=0000bbaa k=3",
                     o_valid, o_data, o_keep);
        end
        drive(0, 8'h00, 1, 0, 1);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty_noop: got v=%0b want 0", o_valid);
        end
        drive(1, 8'h01, 0, 0, 0);
        drive(1, 8'h02, 0, 0, 0);
        drive(1, 8'h03, 0, 0, 0);
        drive(1, 8'h04, 1, 0, 0);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h04030201 || o_keep !== 4'hF) begin
            n_fail++;
            $display("FAIL flush_with_last: got v=%0b d=%h k=%h want v=1 d=04030201 k=f",
                     o_valid, o_data, o_keep);
        end
        drive(1, 8'h05, 1, 0, 1);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h00000005 || o_keep !== 4'h1) begin
            n_fail++;
            $display("FAIL flush_with_sample: got v=%0b d=%h k=%h want v=1 d=00000005 k=1",
                     o_valid, o_data, o_keep);
        end
        drive(0, 8'h00, 0, 0, 1);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_single_word: got v=%0b want 0", o_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 24; i++) drive(1, 8'(i), 0, 0, 0);
        n_checks++;
        if (o_overflow !== 1'b1 || o_drop_count !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow_count: got ovf=%0b cnt=%0d want ovf=1 cnt=2",
                     o_overflow, o_drop_count);
        end
        for (int w = 0; w < 4; w++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== seq_word(4 * w) || o_keep !== 4'hF) begin
                n_fail++;
                $display("FAIL overflow_readout%0d: got v=%0b d=%h k=%h want v=1 d=%h k=f",
                         w, o_valid, o_data, o_keep, seq_word(4 * w));
            end
            drive(0, 8'h00, 0, 0, 1);
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drained: got v=%0b want 0", o_valid);
        end
        drive(0, 8'h00, 0, 1, 0);
        n_checks++;
        if (o_overflow !== 1'b0 || o_drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL overflow_clear: got ovf=%0b cnt=%0d want 0 0", o_overflow, o_drop_count);
        end
        for (int i = 0; i < 28; i++) drive(1, 8'(i), 0, 0, 0);
        n_checks++;
        if (o_drop_count !== 16'd3) begin
            n_fail++;
            $display("FAIL overflow_recount: got cnt=%0d want 3", o_drop_count);
        end
        for (int i = 0; i < 3; i++) drive(1, 8'(i), 0, 0, 0);
        drive(1, 8'h03, 0, 1, 0);
        n_checks++;
        if (o_overflow !== 1'b1 || o_drop_count !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_beats_clear: got ovf=%0b cnt=%0d want ovf=1 cnt=1",
                     o_overflow, o_drop_count);
        end
    endtask

    task automatic test_pop_while_full();
        do_reset();
        for (int i = 0; i < 19; i++) drive(1, 8'(i), 0, 0, 0);
        drive(1, 8'd19, 0, 0, 1);
        n_checks++;
        if (o_overflow !== 1'b0 || o_drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL pop_while_full_ovf: got ovf=%0b cnt=%0d want 0 0",
                     o_overflow, o_drop_count);
        end
        for (int w = 1; w < 5; w++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== seq_word(4 * w)) begin
                n_fail++;
                $display("FAIL pop_while_full_word%0d: got v=%0b d=%h want v=1 d=%h",
                         w, o_valid, o_data, seq_word(4 * w));
            end
            drive(0, 8'h00, 0, 0, 1);
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_while_full_empty: got v=%0b want 0", o_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1, 8'h55, 0, 0, 0);
        drive(1, 8'h66, 0, 0, 0);
        do_reset();
        n_checks++;
        if ({o_valid, o_data, o_keep, o_overflow, o_drop_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got v=%0b d=%h k=%h", o_valid, o_data, o_keep);
        end
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h20 + i), 0, 0, 0);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h23222120 || o_keep !== 4'hF) begin
            n_fail++;
            $display("FAIL mid_reset_word: got v=%0b d=%h k=%h want v=1 d=23222120 k=f",
                     o_valid, o_data, o_keep);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic [3:0]  exp_k;
        bit          exp_v;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1));
            exp_v = (m_wdata.size() > 0);
            exp_d = exp_v ? m_wdata[0] : 32'h0;
            exp_k = exp_v ? m_wkeep[0] : 4'h0;
            n_checks++;
            if (o_valid !== exp_v || o_data !== exp_d || o_keep !== exp_k) begin
                n_fail++;
                $display("FAIL random_word cyc%0d: got v=%0b d=%h k=%h want v=%0b d=%h k=%h",
                         cyc, o_valid, o_data, o_keep, exp_v, exp_d, exp_k);
            end
            n_checks++;
            if (o_overflow !== m_ovf || o_drop_count !== 16'(m_drops)) begin
                n_fail++;
                $display("FAIL random_drops cyc%0d: got ovf=%0b cnt=%0d want ovf=%0b cnt=%0d",
                         cyc, o_overflow, o_drop_count, m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_overflow();
        test_pop_while_full();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
